// File: rtl/audio_pkg.sv
// Shared types and widths for the audio sample fetch path.
package audio_pkg;

    localparam int ADDR_W   = 25;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA,
        DONE
    } fetch_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read data and an occupancy count.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                   clk50,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign do_pop   = pop && !empty;
    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage write port.
    // NOTE: the storage array has no reset; pointers and count alone define which
    // entries are valid, and a reset-free array can map onto block RAM.
    always_ff @(posedge clk50) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk50) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W + 1)'(1);
                2'b01:   count <= count - (PTR_W + 1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_sample_fetcher.sv
// Prefetches 16-bit audio words from RAM into a FIFO and plays them out at the sample rate.
module audio_sample_fetcher
    import audio_pkg::*;
#(
    parameter logic [ADDR_W-1:0] MAX_RAM_ADDRESS = 25'h966F78,
    parameter int                FIFO_DEPTH      = 16,
    parameter logic              LOOP            = 1'b1
) (
    input  logic                clk50,
    input  logic                reset,
    input  logic                init_done,
    input  logic                play_en,
    output logic                rd_req,
    output logic [ADDR_W-1:0]   rd_address,
    input  logic                rd_ack,
    input  logic                rd_valid,
    input  logic [SAMPLE_W-1:0] rd_data,
    input  logic                sample_tick,
    output logic [SAMPLE_W-1:0] sample_out,
    output logic                sample_valid,
    output logic                underrun,
    output logic                done
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(FIFO_DEPTH - 1);

    fetch_state_t        state;
    fetch_state_t        state_next;
    logic [ADDR_W-1:0]   addr_r;
    logic [ADDR_W-1:0]   addr_next;
    logic [ADDR_W-1:0]   addr_inc;
    logic                addr_wrap;
    logic [CNT_W-1:0]    fifo_count;
    logic                fifo_empty;
    logic                fifo_full;
    logic                fifo_push;
    logic                fifo_pop;
    logic [SAMPLE_W-1:0] fifo_data;
    logic                outstanding;
    logic                has_free;
    logic                take_data;
    logic                tick_play;

    sync_fifo #(
        .WIDTH (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk50     (clk50),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (rd_data),
        .pop       (fifo_pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Only one read can be in flight, and it is in flight exactly while waiting for data.
    assign outstanding = (state == WAIT_DATA);
    assign has_free    = (fifo_count + CNT_W'(outstanding)) < DEPTH_C;
    // Data is accepted in WAIT_DATA, or in ISSUE when ack and valid land together.
    assign take_data   = rd_valid && ((state == WAIT_DATA) || ((state == ISSUE) && rd_ack));
    assign addr_inc    = addr_r + ADDR_W'(1);
    assign addr_wrap   = (addr_inc == MAX_RAM_ADDRESS);
    assign rd_address  = addr_r;
    assign tick_play   = sample_tick && play_en;
    assign fifo_pop    = tick_play && !fifo_empty;

    // State and address registers.
    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; blocking here would create order-dependent simulation races.
    always_ff @(posedge clk50) begin
        if (reset) begin
            state  <= IDLE;
            addr_r <= '0;
        end else begin
            state  <= state_next;
            addr_r <= addr_next;
        end
    end

    // Next-state, request and push decode.
    // NOTE: every output of this block is given a default first, so no path leaves a
    // signal unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        addr_next  = addr_r;
        rd_req     = 1'b0;
        fifo_push  = 1'b0;
        done       = (state == DONE) && fifo_empty;

        case (state)
            IDLE:      if (init_done && has_free) state_next = ISSUE;
            ISSUE: begin
                rd_req = 1'b1;
                if (rd_ack) state_next = WAIT_DATA;
            end
            WAIT_DATA: state_next = WAIT_DATA;
            DONE:      state_next = DONE;
            default:   state_next = IDLE;
        endcase

        if (take_data) begin
            fifo_push = 1'b1;
            addr_next = (addr_wrap && LOOP) ? '0 : addr_inc;
            // Re-issue only if a slot remains after this push; a same-cycle pop is
            // ignored here and picked up from IDLE one cycle later.
            if (addr_wrap && !LOOP)          state_next = DONE;
            else if (fifo_count < DEPTH_M1)  state_next = ISSUE;
            else                             state_next = IDLE;
        end
    end

    // Output sample register, valid strobe and sticky underrun flag.
    always_ff @(posedge clk50) begin
        if (reset) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            sample_valid <= tick_play;
            if (tick_play) sample_out <= fifo_empty ? '0 : fifo_data;
            if (tick_play && fifo_empty && (state != DONE)) underrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_audio_sample_fetcher.sv
// Directed bench: three fetcher instances (default, 8-word looping, 8-word one-shot)
// each served by a RAM model with a 2-cycle ack and 3-cycle data return.
module tb_audio_sample_fetcher;

    logic        clk50 = 1'b0;
    logic        reset;
    logic        init_done   [3];
    logic        play_en     [3];
    logic        sample_tick [3];
    logic        stall       [3];
    logic        rd_req      [3];
    logic [24:0] rd_address  [3];
    logic        rd_ack      [3] = '{1'b0, 1'b0, 1'b0};
    logic        rd_valid    [3] = '{1'b0, 1'b0, 1'b0};
    logic [15:0] rd_data     [3] = '{16'h0, 16'h0, 16'h0};
    logic [15:0] sample_out  [3];
    logic        sample_valid[3];
    logic        underrun    [3];
    logic        done        [3];

    int          ack_cnt  [3] = '{0, 0, 0};
    int          val_cnt  [3] = '{0, 0, 0};
    logic        pend     [3] = '{1'b0, 1'b0, 1'b0};
    logic [24:0] pend_addr[3] = '{25'h0, 25'h0, 25'h0};

    logic [24:0] ack_log0[$];
    logic [24:0] ack_log1[$];
    logic [24:0] ack_log2[$];

    int total = 0;
    int bad   = 0;

    always #5 clk50 = ~clk50;

    audio_sample_fetcher u_dut_main (
        .clk50(clk50), .reset(reset), .init_done(init_done[0]), .play_en(play_en[0]),
        .rd_req(rd_req[0]), .rd_address(rd_address[0]), .rd_ack(rd_ack[0]),
        .rd_valid(rd_valid[0]), .rd_data(rd_data[0]), .sample_tick(sample_tick[0]),
        .sample_out(sample_out[0]), .sample_valid(sample_valid[0]),
        .underrun(underrun[0]), .done(done[0])
    );

    audio_sample_fetcher #(.MAX_RAM_ADDRESS(25'd8), .FIFO_DEPTH(16), .LOOP(1'b1)) u_dut_loop (
        .clk50(clk50), .reset(reset), .init_done(init_done[1]), .play_en(play_en[1]),
        .rd_req(rd_req[1]), .rd_address(rd_address[1]), .rd_ack(rd_ack[1]),
        .rd_valid(rd_valid[1]), .rd_data(rd_data[1]), .sample_tick(sample_tick[1]),
        .sample_out(sample_out[1]), .sample_valid(sample_valid[1]),
        .underrun(underrun[1]), .done(done[1])
    );

    audio_sample_fetcher #(.MAX_RAM_ADDRESS(25'd8), .FIFO_DEPTH(16), .LOOP(1'b0)) u_dut_stop (
        .clk50(clk50), .reset(reset), .init_done(init_done[2]), .play_en(play_en[2]),
        .rd_req(rd_req[2]), .rd_address(rd_address[2]), .rd_ack(rd_ack[2]),
        .rd_valid(rd_valid[2]), .rd_data(rd_data[2]), .sample_tick(sample_tick[2]),
        .sample_out(sample_out[2]), .sample_valid(sample_valid[2]),
        .underrun(underrun[2]), .done(done[2])
    );

    // RAM model: ack two cycles into a request, data three cycles after ack; word n = n.
    always @(posedge clk50) begin
        for (int i = 0; i < 3; i++) begin
            rd_ack[i]   <= 1'b0;
            rd_valid[i] <= 1'b0;
            if (!rd_req[i]) begin
                ack_cnt[i] <= 0;
            end else if (!rd_ack[i] && !stall[i]) begin
                if (ack_cnt[i] == 1) begin
                    rd_ack[i]    <= 1'b1;
                    ack_cnt[i]   <= 0;
                    pend[i]      <= 1'b1;
                    pend_addr[i] <= rd_address[i];
                    val_cnt[i]   <= 0;
                end else begin
                    ack_cnt[i] <= ack_cnt[i] + 1;
                end
            end
            if (pend[i]) begin
                if (val_cnt[i] == 2) begin
                    rd_valid[i] <= 1'b1;
                    rd_data[i]  <= pend_addr[i][15:0];
                    pend[i]     <= 1'b0;
                end else begin
                    val_cnt[i] <= val_cnt[i] + 1;
                end
            end
        end
    end

    // Log every accepted request address per instance.
    always @(negedge clk50) begin
        if (!reset) begin
            if (rd_req[0] && rd_ack[0]) ack_log0.push_back(rd_address[0]);
            if (rd_req[1] && rd_ack[1]) ack_log1.push_back(rd_address[1]);
            if (rd_req[2] && rd_ack[2]) ack_log2.push_back(rd_address[2]);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk50);
    endtask

    // Drive a one-cycle tick; returns on the negedge where the registered sample is visible.
    task automatic do_tick(input int i);
        @(negedge clk50);
        sample_tick[i] = 1'b1;
        @(negedge clk50);
        sample_tick[i] = 1'b0;
    endtask

    initial begin
        int wait_cnt;
        logic [31:0] exp_val;

        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            init_done[i]   = 1'b0;
            play_en[i]     = 1'b0;
            sample_tick[i] = 1'b0;
            stall[i]       = 1'b0;
        end
        cycles(3);

        // Reset values.
        check("rst_rd_req",       rd_req[0],       0);
        check("rst_rd_address",   rd_address[0],   0);
        check("rst_sample_out",   sample_out[0],   0);
        check("rst_sample_valid", sample_valid[0], 0);
        check("rst_underrun",     underrun[0],     0);
        check("rst_done",         done[0],         0);
        reset = 1'b0;

        // Prefetch fills the FIFO with words 0..15 and then stops requesting.
        init_done[0] = 1'b1;
        cycles(200);
        check("fill_reads", ack_log0.size(), 16);
        for (int k = 0; k < 16; k++) check($sformatf("fill_addr_%0d", k), ack_log0[k], k);
        check("fill_idle_req", rd_req[0], 0);

        // Playback: ticks every 20 cycles produce 0,1,2,... with a single-cycle valid pulse.
        play_en[0] = 1'b1;
        for (int k = 0; k < 24; k++) begin
            do_tick(0);
            check($sformatf("play_out_%0d", k), sample_out[0], k);
            check($sformatf("play_vld_%0d", k), sample_valid[0], 1);
            cycles(1);
            check($sformatf("play_vld_low_%0d", k), sample_valid[0], 0);
            cycles(17);
        end
        check("play_underrun", underrun[0], 0);
        cycles(100);

        // RAM stall: FIFO (24..39) drains, then silence with sticky underrun.
        stall[0] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            do_tick(0);
            exp_val = (k < 16) ? 32'(24 + k) : 32'd0;
            check($sformatf("stall_out_%0d", k), sample_out[0], exp_val);
            check($sformatf("stall_urun_%0d", k), underrun[0], (k >= 16) ? 1 : 0);
            cycles(18);
        end
        stall[0] = 1'b0;
        cycles(150);
        check("recover_urun_sticky", underrun[0], 1);
        do_tick(0);
        check("recover_out", sample_out[0], 40);
        cycles(100);

        // Looping 8-word image: addresses wrap 0..7,0,1 and the stream wraps too.
        init_done[1] = 1'b1;
        cycles(200);
        check("loop_reads", ack_log1.size(), 16);
        for (int k = 0; k < 10; k++) check($sformatf("loop_addr_%0d", k), ack_log1[k], k % 8);
        play_en[1] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            do_tick(1);
            check($sformatf("loop_out_%0d", k), sample_out[1], k % 8);
            cycles(18);
        end
        check("loop_underrun", underrun[1], 0);

        // One-shot 8-word image: 8 reads, then DONE; done after draining; 9th tick silent.
        init_done[2] = 1'b1;
        cycles(200);
        check("stop_reads", ack_log2.size(), 8);
        for (int k = 0; k < 8; k++) check($sformatf("stop_addr_%0d", k), ack_log2[k], k);
        check("stop_no_req", rd_req[2], 0);
        check("stop_done_early", done[2], 0);
        play_en[2] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            do_tick(2);
            check($sformatf("stop_out_%0d", k), sample_out[2], k);
            cycles(18);
        end
        check("stop_done", done[2], 1);
        do_tick(2);
        check("stop_tail_out", sample_out[2], 0);
        check("stop_tail_urun", underrun[2], 0);

        // Reset while a request is accepted; the stale data must not enter the FIFO.
        init_done[1] = 1'b0;
        init_done[2] = 1'b0;
        do_tick(0);
        check("pre_rst_out", sample_out[0], 41);
        wait_cnt = 0;
        while (!rd_ack[0] && wait_cnt < 50) begin
            @(negedge clk50);
            wait_cnt++;
        end
        check("pre_rst_ack_seen", rd_ack[0], 1);
        check("pre_rst_req", rd_req[0], 1);
        init_done[0] = 1'b0;
        reset = 1'b1;
        cycles(1);
        check("mid_rst_rd_req",       rd_req[0],       0);
        check("mid_rst_rd_address",   rd_address[0],   0);
        check("mid_rst_sample_out",   sample_out[0],   0);
        check("mid_rst_sample_valid", sample_valid[0], 0);
        check("mid_rst_underrun",     underrun[0],     0);
        check("mid_rst_done",         done[0],         0);
        reset = 1'b0;
        cycles(10);
        check("post_rst_rd_req", rd_req[0], 0);
        check("post_rst_out",    sample_out[0], 0);
        ack_log0.delete();
        init_done[0] = 1'b1;
        cycles(150);
        check("restart_reads", ack_log0.size(), 16);
        check("restart_addr0", ack_log0[0], 0);
        do_tick(0);
        check("restart_first_out", sample_out[0], 0);
        do_tick(0);
        check("restart_second_out", sample_out[0], 1);
        check("restart_underrun", underrun[0], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
